// File: rtl/calc_sequencer.sv
// Command-level controller for one calculator: it loads A, waits, calcs with B, waits, then responds.
// When CALC_SEQ_TIMEOUT_EN is defined, a wait that lasts TIMEOUT cycles aborts with rsp_err=1.
module calc_sequencer #(
  parameter int unsigned W       = 8,
  parameter int unsigned SETTLE  = 1,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [W-1:0] req_a,
  input  logic [W-1:0] req_b,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_data,
  output logic         rsp_err,
  output logic         busy,
  output logic         calc_load,
  output logic         calc_calc,
  output logic [W-1:0] calc_in,
  input  logic         calc_ready,
  input  logic [W-1:0] calc_out
);
  typedef enum logic [2:0] {StIdle, StLoad, StWaitL, StCalc, StWaitC, StResp} state_e;

  localparam logic [3:0] SettleCyc = 4'(SETTLE);

  state_e       state_q, state_d;
  logic [W-1:0] a_q, a_d, b_q, b_d, data_q, data_d;
  logic [3:0]   settle_q, settle_d;
  logic         req_ready_q, req_ready_d;
  logic         in_wait, qual_ready, expired;

  assign in_wait    = (state_q == StWaitL) || (state_q == StWaitC);
  assign qual_ready = in_wait && (settle_q >= SettleCyc) && calc_ready;

  // Settle counter saturates at SETTLE and is zero outside wait states, so each wait starts fresh.
  always_comb begin
    settle_d = 4'd0;
    if (in_wait) settle_d = (settle_q < SettleCyc) ? settle_q + 4'd1 : settle_q;
  end

`ifdef CALC_SEQ_TIMEOUT_EN
  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT - 1);

  logic [15:0] tmo_q, tmo_d;
  logic        err_q, err_d;

  assign expired = in_wait && !qual_ready && (tmo_q == TimeoutLast);

  always_comb begin
    tmo_d = 16'd0;
    if (in_wait && !qual_ready) tmo_d = tmo_q + 16'd1;
    err_d = err_q;
    if (expired) err_d = 1'b1;
    else if (state_q == StWaitC && qual_ready) err_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmo_q <= 16'd0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end

  assign rsp_err = err_q;
`else
  assign expired = 1'b0;
  assign rsp_err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    data_d  = data_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid && req_ready_q) begin
          a_d     = req_a;
          b_d     = req_b;
          state_d = StLoad;
        end
      end
      StLoad:  state_d = StWaitL;
      StWaitL: begin
        if (expired) begin
          data_d  = '0;
          state_d = StResp;
        end else if (qual_ready) begin
          state_d = StCalc;
        end
      end
      StCalc:  state_d = StWaitC;
      StWaitC: begin
        if (expired) begin
          data_d  = '0;
          state_d = StResp;
        end else if (qual_ready) begin
          data_d  = calc_out;
          state_d = StResp;
        end
      end
      StResp:  if (rsp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
    req_ready_d = (state_d == StIdle);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      a_q         <= '0;
      b_q         <= '0;
      data_q      <= '0;
      settle_q    <= 4'd0;
      req_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      data_q      <= data_d;
      settle_q    <= settle_d;
      req_ready_q <= req_ready_d;
    end
  end

  // Pulses decode straight from the async-reset state, so they drop the moment reset asserts.
  assign busy      = (state_q != StIdle);
  assign rsp_valid = (state_q == StResp);
  assign calc_load = (state_q == StLoad);
  assign calc_calc = (state_q == StCalc);
  assign calc_in   = (state_q == StCalc) ? b_q : a_q;
  assign req_ready = req_ready_q;
  assign rsp_data  = data_q;

endmodule

// File: doc/calc_sequencer.md
Name: calc_sequencer

Overview:
- Command-level controller for the simple calculator datapath (load/calc/in/ready/out interface, width W).
- Accepts one two-operand request (A, B) on a valid/ready handshake, then sequences the calculator: load A, wait, calc with B, wait.
- Returns the captured result on a valid/ready response channel.
- Sits between a host/command source and one calculator instance; exactly one request in flight.

Parameters:
- W, 8, operand/result width; must match the calculator's W.
- SETTLE, 1, cycles after each load/calc pulse during which calc_ready is ignored; range 0..15.
- TIMEOUT, 255, max cycles spent in one wait state before abort (optional feature only); range 1..65535.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept a request.
- req_a  in  W  first operand, loaded into the calculator.
- req_b  in  W  second operand, applied with calc.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer takes the response.
- rsp_data  out  W  captured calculator result.
- rsp_err  out  1  timeout abort flag; constant 0 without the optional feature.
- busy  out  1  high in every state except IDLE.
- calc_load  out  1  to calculator load.
- calc_calc  out  1  to calculator calc.
- calc_in  out  W  to calculator in.
- calc_ready  in  1  from calculator ready.
- calc_out  in  W  from calculator out.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - All outputs are 0 except req_ready=1.
  - Operand registers, rsp_data and counters are cleared.
  - Reset mid-operation aborts the request with no response.
  - calc_load and calc_calc drop in the same cycle reset asserts.
- States: IDLE, LOAD, WAIT_L, CALC, WAIT_C, RESP.
- IDLE:
  - req_ready=1 (registered; 1 only in IDLE).
  - On req_valid&&req_ready, latch req_a/req_b and go to LOAD.
- LOAD: calc_load=1 and calc_in=A for exactly one cycle, then WAIT_L.
- WAIT_L:
  - calc_ready is ignored for the first SETTLE cycles.
  - After that, calc_ready=1 moves to CALC.
- CALC: calc_calc=1 and calc_in=B for exactly one cycle, then WAIT_C.
- WAIT_C:
  - Same SETTLE rule as WAIT_L.
  - On calc_ready=1, capture calc_out into rsp_data, clear rsp_err, and go to RESP.
- RESP:
  - rsp_valid=1; rsp_data and rsp_err stay stable until rsp_ready=1.
  - On handshake, go to IDLE; req_ready=1 the next cycle. No back-to-back accept in the handshake cycle.
- calc_load and calc_calc are never high together.
- calc_in is B in CALC and A in every other state.
- rsp_data keeps its last value after RESP, until the next capture or reset.
- busy = (state != IDLE).
- Latency with SETTLE=1 and calc_ready held at 1:
  - Accept at edge 0; LOAD in cycle 1; WAIT_L in cycles 2–3; CALC in cycle 4; WAIT_C in cycles 5–6.
  - rsp_valid first high in cycle 7.
  - General form: 5 + 2·SETTLE cycles.
- SETTLE=0: calc_ready is sampled in the first wait cycle.
- A request arriving while busy is not accepted; the source must hold req_valid and operands stable.

Optional Feature:
- Macro: CALC_SEQ_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT_L/WAIT_C and is cleared on entry to each wait state.
  - If TIMEOUT cycles pass without qualifying calc_ready, go to RESP with rsp_err=1 and rsp_data=0.
  - The abort skips CALC if it happens in WAIT_L.
- Undefined:
  - No counter logic; wait states wait indefinitely.
  - rsp_err is tied to 0.

Test Plan:
- Basic sequence: reset low 3 cycles then high; stub calculator (out=A+B, ready delay 2); req A=8'h12, B=8'h34 -> exactly one calc_load with calc_in=12, then one calc_calc with calc_in=34; rsp_valid with rsp_data=8'h46, rsp_err=0.
- Latency and backpressure: SETTLE=1, stub ready always 1; rsp_ready held 0 for 5 cycles -> rsp_valid first at cycle 7 after accept; rsp_data stable while held; req_ready=0 throughout; back to IDLE one cycle after rsp_ready.
- Busy rejection: second req_valid (A=1, B=2) held during the first operation -> accepted only after the first RESP handshake; two responses delivered in order.
- Mid-operation reset: assert reset during WAIT_C -> calc_load, calc_calc, rsp_valid and busy go 0 asynchronously; req_ready=1 after release; no response emitted.
- Wrap-around: A=8'hFF, B=8'h02 with stub out=A+B -> rsp_data=8'h01.
- Timeout (CALC_SEQ_TIMEOUT_EN, TIMEOUT=10): stub never raises ready after load -> rsp_valid after 10 WAIT_L cycles with rsp_err=1, rsp_data=0; calc_calc never pulses. Without the macro, rsp_valid stays 0 for 1000 cycles.
